// File: rtl/tpu_stream_pkg.sv
// tpu_stream_pkg: shared state type and sizing constants for the TPU operand streamer.
package tpu_stream_pkg;
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_COLLECT, S_FLUSH, S_DONE, S_ERROR} state_e;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RD_LATENCY = 1;
endpackage

// File: rtl/tpu_skid_fifo.sv
// tpu_skid_fifo: small skid FIFO decoupling scratchpad read returns from the array handshake.
module tpu_skid_fifo
    import tpu_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic [FIFO_CW-1:0] count,
    output logic               empty,
    output logic               full
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_CW-1:0] count_q, count_d;
    logic               do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FIFO_CW'(FIFO_DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = do_push ? ((wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop ? ((rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/tpu_operand_streamer.sv
// tpu_operand_streamer: streams scratchpad operand pairs into the compute array and writes its results back.
module tpu_operand_streamer
    import tpu_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_src_a_base,
    input  logic [ADDR_WIDTH-1:0] cfg_src_b_base,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
    input  logic [LEN_WIDTH-1:0]  cfg_in_len,
    input  logic [LEN_WIDTH-1:0]  cfg_out_len,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_b,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_a,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_b,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data_a,
    output logic [DATA_WIDTH-1:0] tx_data_b,
    input  logic                  tx_ready,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  sent_count,
    output logic [LEN_WIDTH-1:0]  recv_count
);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    in_len_q, in_len_d, out_len_q, out_len_d;
    logic [LEN_WIDTH-1:0]    issued_q, issued_d, sent_q, sent_d, recv_q, recv_d;
    logic [WDW-1:0]          wd_q, wd_d;
    logic [RD_LATENCY-1:0]   inflight_q, inflight_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rd_en, start_ok, fifo_pop, fifo_empty, fifo_full;
    logic [FIFO_CW-1:0]      fifo_count;
    logic [2*DATA_WIDTH-1:0] fifo_dout;

    tpu_skid_fifo #(.WIDTH(2 * DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg_abort),
        .push  (inflight_q[RD_LATENCY-1]),
        .din   ({mem_rd_data_a, mem_rd_data_b}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign tx_valid      = (state_q == S_STREAM) && !fifo_empty;
    assign {tx_data_a, tx_data_b} = fifo_dout;
    assign fifo_pop      = tx_valid && tx_ready;
    // reads in flight are counted against FIFO space so returned data always has a slot
    assign rd_en         = (state_q == S_STREAM) && !cfg_abort && (issued_q < in_len_q) && !(fifo_full && !fifo_pop)
                         && (int'(fifo_count) + $countones(inflight_q) - int'(fifo_pop) < int'(FIFO_DEPTH));
    assign mem_rd_en     = rd_en;
    assign mem_rd_addr_a = base_a_q + ADDR_WIDTH'(issued_q);
    assign mem_rd_addr_b = base_b_q + ADDR_WIDTH'(issued_q);
    assign rx_ready      = (state_q == S_COLLECT);
    assign mem_wr_en     = wr_en_q;
    assign mem_wr_addr   = wr_addr_q;
    assign mem_wr_data   = wr_data_q;
    assign busy          = (state_q == S_STREAM) || (state_q == S_COLLECT) || (state_q == S_FLUSH);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign sent_count    = sent_q;
    assign recv_count    = recv_q;
    assign start_ok      = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

    always_comb begin
        state_d    = state_q;
        base_a_d   = base_a_q;
        base_b_d   = base_b_q;
        dst_d      = dst_q;
        in_len_d   = in_len_q;
        out_len_d  = out_len_q;
        issued_d   = issued_q + LEN_WIDTH'(rd_en);
        sent_d     = sent_q + LEN_WIDTH'(fifo_pop);
        recv_d     = recv_q;
        wd_d       = wd_q;
        inflight_d = RD_LATENCY'({inflight_q, rd_en});
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (cfg_abort) begin
            state_d    = S_IDLE;
            inflight_d = '0;
        end else if (start_ok) begin
            base_a_d  = cfg_src_a_base;
            base_b_d  = cfg_src_b_base;
            dst_d     = cfg_dst_base;
            in_len_d  = cfg_in_len;
            out_len_d = cfg_out_len;
            issued_d  = '0;
            sent_d    = '0;
            recv_d    = '0;
            wd_d      = '0;
            state_d   = (cfg_in_len != '0) ? S_STREAM : (cfg_out_len != '0) ? S_COLLECT : S_DONE;
        end else begin
            case (state_q)
                S_STREAM: if (fifo_pop && sent_d == in_len_q) state_d = (out_len_q != '0) ? S_COLLECT : S_DONE;
                S_COLLECT: begin
                    if (rx_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = dst_q + ADDR_WIDTH'(recv_q);
                        wr_data_d = rx_data;
                        recv_d    = recv_q + 1'b1;
                        wd_d      = '0;
                        if (recv_d == out_len_q) state_d = S_FLUSH;
                    end else begin
                        wd_d = wd_q + 1'b1;
                        if (wd_d == WDW'(TIMEOUT_CYCLES)) state_d = S_ERROR;
                    end
                end
                S_FLUSH: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_a_q   <= '0;
            base_b_q   <= '0;
            dst_q      <= '0;
            in_len_q   <= '0;
            out_len_q  <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            wd_q       <= '0;
            inflight_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_a_q   <= base_a_d;
            base_b_q   <= base_b_d;
            dst_q      <= dst_d;
            in_len_q   <= in_len_d;
            out_len_q  <= out_len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            wd_q       <= wd_d;
            inflight_q <= inflight_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_tpu_operand_streamer.sv
// tb_tpu_operand_streamer: directed self-checking bench for the operand streamer.
module tb_tpu_operand_streamer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [15:0] cfg_src_a_base = '0, cfg_src_b_base = '0, cfg_dst_base = '0;
    logic [15:0] cfg_in_len = '0, cfg_out_len = '0;
    logic        mem_rd_en, tx_valid, rx_ready, mem_wr_en, busy, done, error;
    logic [15:0] mem_rd_addr_a, mem_rd_addr_b, mem_wr_addr, sent_count, recv_count;
    logic [31:0] mem_rd_data_a = '0, mem_rd_data_b = '0, tx_data_a, tx_data_b, mem_wr_data;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [31:0] rx_data = '0;

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] rd_a_q[$], rd_b_q[$];
    logic [63:0] tx_q[$];
    logic [47:0] wr_q[$];
    int          reads, beats, done_cnt, max_out, stall_err;
    bit          stall_pend;
    logic [63:0] stall_data;

    tpu_operand_streamer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_src_a_base(cfg_src_a_base), .cfg_src_b_base(cfg_src_b_base), .cfg_dst_base(cfg_dst_base),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
        .mem_rd_data_a(mem_rd_data_a), .mem_rd_data_b(mem_rd_data_b),
        .tx_valid(tx_valid), .tx_data_a(tx_data_a), .tx_data_b(tx_data_b), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .error(error), .sent_count(sent_count), .recv_count(recv_count)
    );

    always #5 clk = ~clk;

    // scratchpad: A[base+i] = 0x10+i, B[base+i] = 0x20+i, one-cycle read latency
    always @(posedge clk) begin
        mem_rd_data_a <= 32'h10 + 32'(16'(mem_rd_addr_a - cfg_src_a_base));
        mem_rd_data_b <= 32'h20 + 32'(16'(mem_rd_addr_b - cfg_src_b_base));
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_a_q.push_back(mem_rd_addr_a);
            rd_b_q.push_back(mem_rd_addr_b);
            reads++;
        end
        if (tx_valid && tx_ready) begin
            tx_q.push_back({tx_data_a, tx_data_b});
            beats++;
        end
        if (reads - beats > max_out) max_out = reads - beats;
        if (stall_pend && (!tx_valid || {tx_data_a, tx_data_b} != stall_data)) stall_err++;
        stall_pend = tx_valid && !tx_ready;
        stall_data = {tx_data_a, tx_data_b};
        if (mem_wr_en) wr_q.push_back({mem_wr_addr, mem_wr_data});
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        rd_a_q.delete(); rd_b_q.delete(); tx_q.delete(); wr_q.delete();
        reads = 0; beats = 0; done_cnt = 0; max_out = 0; stall_err = 0; stall_pend = 0;
    endtask

    task automatic start_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                             input logic [15:0] il, input logic [15:0] ol);
        cfg_src_a_base = a; cfg_src_b_base = b; cfg_dst_base = d; cfg_in_len = il; cfg_out_len = ol;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == c0; i++) tick();
        ok = (done_cnt != c0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %0h want 0", tx_valid); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rx_ready got %0h want 0", rx_ready); end
        n_cmp++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_bad++; $display("FAIL rst_mem_en got %0h want 0", {mem_rd_en, mem_wr_en}); end
        n_cmp++; if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL rst_status got %0h want 0", {busy, done, error}); end
        n_cmp++; if ({sent_count, recv_count} !== 32'h0) begin n_bad++; $display("FAIL rst_counts got %0h want 0", {sent_count, recv_count}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({busy, done, error, tx_valid, mem_rd_en} !== 5'b0) begin n_bad++; $display("FAIL post_rst_idle got %0h want 0", {busy, done, error, tx_valid, mem_rd_en}); end
    endtask

    task automatic test_basic();
        clr_mon();
        tx_ready = 1'b1;
        start_job(16'h0100, 16'h0200, 16'h0300, 16'd4, 16'd4);
        n_cmp++; if ({mem_rd_en, busy} !== 2'b11) begin n_bad++; $display("FAIL basic_e0_rd got %0h want 3", {mem_rd_en, busy}); end
        n_cmp++; if ({mem_rd_addr_a, mem_rd_addr_b} !== 32'h0100_0200) begin n_bad++; $display("FAIL basic_e0_addr got %0h want 01000200", {mem_rd_addr_a, mem_rd_addr_b}); end
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_e1_tx_valid got %0h want 0", tx_valid); end
        tick();
        n_cmp++; if ({tx_valid, tx_data_a, tx_data_b} !== {1'b1, 32'h10, 32'h20}) begin n_bad++; $display("FAIL basic_e2_tx got %0h want 1_00000010_00000020", {tx_valid, tx_data_a, tx_data_b}); end
        repeat (4) tick();
        n_cmp++; if ({rx_ready, sent_count} !== {1'b1, 16'd4}) begin n_bad++; $display("FAIL basic_collect got %0h want 10004", {rx_ready, sent_count}); end
        n_cmp++; if (tx_q.size() !== 4 || reads !== 4) begin n_bad++; $display("FAIL basic_counts got beats=%0d reads=%0d want 4 4", tx_q.size(), reads); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== {32'(32'h10 + i), 32'(32'h20 + i)}) begin n_bad++; $display("FAIL basic_tx_beat%0d got %0h want %0h", i, tx_q[i], {32'(32'h10 + i), 32'(32'h20 + i)}); end
        end
        for (int k = 0; k < 4; k++) begin
            rx_valid = 1'b1;
            rx_data  = 32'hD0 + k;
            tick();
            n_cmp++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 16'(16'h0300 + k), 32'(32'hD0 + k)}) begin n_bad++; $display("FAIL basic_wr%0d got %0h want %0h", k, {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 16'(16'h0300 + k), 32'(32'hD0 + k)}); end
            n_cmp++; if (recv_count !== 16'(k + 1)) begin n_bad++; $display("FAIL basic_recv%0d got %0d want %0d", k, recv_count, k + 1); end
        end
        rx_valid = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL basic_flush got %0h want 2", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done, mem_wr_en} !== 3'b010) begin n_bad++; $display("FAIL basic_done got %0h want 2", {busy, done, mem_wr_en}); end
        tick();
        n_cmp++; if (done !== 1'b0 || done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_pulse got done=%0h cnt=%0d want 0 1", done, done_cnt); end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        pat = 4'b1001;
        clr_mon();
        tx_ready = 1'b1;
        start_job(16'h0040, 16'h0080, 16'h0000, 16'd6, 16'd0);
        for (int c = 0; c < 80 && done_cnt == 0; c++) begin
            tx_ready = pat[c % 4];
            tick();
        end
        repeat (3) tick();
        n_cmp++; if (tx_q.size() !== 6 || reads !== 6) begin n_bad++; $display("FAIL stall_counts got beats=%0d reads=%0d want 6 6", tx_q.size(), reads); end
        for (int i = 0; i < 6 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== {32'(32'h10 + i), 32'(32'h20 + i)}) begin n_bad++; $display("FAIL stall_tx_beat%0d got %0h want %0h", i, tx_q[i], {32'(32'h10 + i), 32'(32'h20 + i)}); end
        end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL stall_stability got %0d unstable cycles want 0", stall_err); end
        n_cmp++; if (max_out > 2) begin n_bad++; $display("FAIL stall_credit got %0d outstanding want <=2", max_out); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done got %0d pulses want 1", done_cnt); end
        tx_ready = 1'b1;
    endtask

    task automatic test_wrap();
        bit ok;
        clr_mon();
        tx_ready = 1'b1;
        start_job(16'hFFFE, 16'hFFFF, 16'h0000, 16'd4, 16'd0);
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done got timeout want done"); end
        n_cmp++; if (rd_a_q.size() !== 4) begin n_bad++; $display("FAIL wrap_reads got %0d want 4", rd_a_q.size()); end
        for (int i = 0; i < 4 && i < rd_a_q.size(); i++) begin
            n_cmp++; if ({rd_a_q[i], rd_b_q[i]} !== {16'(16'hFFFE + i), 16'(16'hFFFF + i)}) begin n_bad++; $display("FAIL wrap_addr%0d got %0h want %0h", i, {rd_a_q[i], rd_b_q[i]}, {16'(16'hFFFE + i), 16'(16'hFFFF + i)}); end
        end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== {32'(32'h10 + i), 32'(32'h20 + i)}) begin n_bad++; $display("FAIL wrap_tx_beat%0d got %0h want %0h", i, tx_q[i], {32'(32'h10 + i), 32'(32'h20 + i)}); end
        end
    endtask

    task automatic test_zero();
        clr_mon();
        start_job(16'h0010, 16'h0020, 16'h0030, 16'd0, 16'd0);
        n_cmp++; if ({done, busy, mem_rd_en} !== 3'b100) begin n_bad++; $display("FAIL zero_done got %0h want 4", {done, busy, mem_rd_en}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse got %0h want 0", done); end
        tick();
        n_cmp++; if (reads !== 0 || beats !== 0 || wr_q.size() !== 0 || done_cnt !== 1) begin n_bad++; $display("FAIL zero_activity got rd=%0d tx=%0d wr=%0d done=%0d want 0 0 0 1", reads, beats, wr_q.size(), done_cnt); end
    endtask

    task automatic test_timeout();
        clr_mon();
        start_job(16'h0000, 16'h0000, 16'h0500, 16'd0, 16'd2);
        n_cmp++; if ({rx_ready, busy} !== 2'b11) begin n_bad++; $display("FAIL to_collect got %0h want 3", {rx_ready, busy}); end
        for (int i = 1; i <= 15; i++) begin
            cfg_start = (i == 5);
            tick();
        end
        cfg_start = 1'b0;
        n_cmp++; if ({error, rx_ready} !== 2'b01) begin n_bad++; $display("FAIL to_before_limit got %0h want 1", {error, rx_ready}); end
        tick();
        n_cmp++; if ({error, rx_ready, busy} !== 3'b100) begin n_bad++; $display("FAIL to_error got %0h want 4", {error, rx_ready, busy}); end
        repeat (2) tick();
        n_cmp++; if ({error, tx_valid} !== 2'b10) begin n_bad++; $display("FAIL to_error_hold got %0h want 2", {error, tx_valid}); end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_cmp++; if ({error, busy, rx_ready, done} !== 4'b0) begin n_bad++; $display("FAIL to_abort got %0h want 0", {error, busy, rx_ready, done}); end
    endtask

    task automatic test_abort_replay();
        bit ok;
        clr_mon();
        tx_ready = 1'b1;
        start_job(16'h0700, 16'h0800, 16'h0900, 16'd6, 16'd2);
        repeat (4) tick();
        tx_ready  = 1'b0;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_cmp++; if ({busy, tx_valid, mem_rd_en, done, error} !== 5'b0) begin n_bad++; $display("FAIL abort_idle got %0h want 0", {busy, tx_valid, mem_rd_en, done, error}); end
        n_cmp++; if (beats !== 2) begin n_bad++; $display("FAIL abort_beats got %0d want 2", beats); end
        repeat (3) tick();
        n_cmp++; if (done_cnt !== 0 || wr_q.size() !== 0) begin n_bad++; $display("FAIL abort_quiet got done=%0d wr=%0d want 0 0", done_cnt, wr_q.size()); end
        clr_mon();
        tx_ready = 1'b1;
        start_job(16'h0700, 16'h0800, 16'h0900, 16'd6, 16'd2);
        for (int i = 0; i < 100 && !rx_ready; i++) tick();
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL replay_collect got %0h want 1", rx_ready); end
        for (int k = 0; k < 2; k++) begin
            rx_valid = 1'b1;
            rx_data  = 32'hE0 + k;
            tick();
        end
        rx_valid = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL replay_done got timeout want done"); end
        n_cmp++; if (tx_q.size() !== 6) begin n_bad++; $display("FAIL replay_beats got %0d want 6", tx_q.size()); end
        for (int i = 0; i < 6 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== {32'(32'h10 + i), 32'(32'h20 + i)}) begin n_bad++; $display("FAIL replay_tx_beat%0d got %0h want %0h", i, tx_q[i], {32'(32'h10 + i), 32'(32'h20 + i)}); end
        end
        n_cmp++; if (wr_q.size() !== 2) begin n_bad++; $display("FAIL replay_writes got %0d want 2", wr_q.size()); end
        for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
            n_cmp++; if (wr_q[k] !== {16'(16'h0900 + k), 32'(32'hE0 + k)}) begin n_bad++; $display("FAIL replay_wr%0d got %0h want %0h", k, wr_q[k], {16'(16'h0900 + k), 32'(32'hE0 + k)}); end
        end
        tick();
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL replay_done_pulse got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero();
        test_timeout();
        test_abort_replay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
